// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op_e      : operation codes presented on the issue bus
//   - state_e   : control FSM encoding
//   - hilo_t    : HI/LO result pair
//   - default latencies and the combinational multiply/divide helpers
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // 32x32 -> 64 product; signed operands are sign-extended so the low
    // 64 bits of the 64x64 product are the correct two's-complement result.
    function automatic hilo_t mul_op(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        logic [63:0] p;
        ax = is_signed ? {{32{a[31]}}, a} : {32'h0000_0000, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'h0000_0000, b};
        p  = ax * bx;
        return '{hi: p[63:32], lo: p[31:0]};
    endfunction

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // naturally as 0x80000000 rem 0. A zero divisor is replaced by 1 so the
    // arithmetic never yields X; the caller discards that result.
    function automatic hilo_t div_op(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed);
        logic        a_neg;
        logic        b_neg;
        logic [31:0] a_mag;
        logic [31:0] b_mag;
        logic [31:0] q;
        logic [31:0] r;
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        if (b_mag == 32'd0) begin
            b_mag = 32'd1;
        end else begin
            b_mag = b_mag;
        end
        q = a_mag / b_mag;
        r = a_mag % b_mag;
        return '{hi: (a_neg ? (32'd0 - r) : r),
                 lo: ((a_neg ^ b_neg) ? (32'd0 - q) : q)};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: issue/result bus between the datapath and the multiply/divide unit.
//   start   : issue strobe; op/rs_data/rt_data valid this cycle
//   op      : operation code (mdu_pkg::op_e values, undefined codes ignored)
//   rs_data : GRF read port 1 (dividend / multiplicand / mthi-mtlo source)
//   rt_data : GRF read port 2 (divisor / multiplier)
//   busy    : operation in flight, HI/LO not yet valid
//   hi, lo  : architectural HI/LO registers
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs_data, rt_data, input busy, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning HI/LO.
//   clk   : core clock, all state changes on the rising edge
//   reset : synchronous active-high, clears all state and aborts an operation
//   bus   : mdu_if.slave issue/result bus (start, op, rs_data, rt_data in;
//           busy, hi, lo out)
// Results are computed combinationally at issue into shadow registers and
// released to HI/LO when the latency counter expires, so busy and the result
// timing match a multi-cycle unit exactly.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        hi_n_q, hi_n_d;
    logic [31:0]        lo_n_q, lo_n_d;

    hilo_t              mul_res_s;
    hilo_t              div_res_s;

    // Arithmetic on the issue-cycle operands.
    always_comb begin
        mul_res_s = mul_op(bus.rs_data, bus.rt_data, bus.op == OP_MULT);
        div_res_s = div_op(bus.rs_data, bus.rt_data, bus.op == OP_DIV);
    end

    // Next-state logic: issue decode in IDLE, countdown and release in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            hi_n_d  = mul_res_s.hi;
                            lo_n_d  = mul_res_s.lo;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the full latency
                            // but releases the current HI/LO unchanged; nothing
                            // else can write HI/LO while busy.
                            if (bus.rt_data == 32'd0) begin
                                hi_n_d = hi_q;
                                lo_n_d = lo_q;
                            end else begin
                                hi_n_d = div_res_s.hi;
                                lo_n_d = div_res_s.lo;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_BUSY;
                        end
                        OP_MTHI: hi_d = bus.rs_data;
                        OP_MTLO: lo_d = bus.rs_data;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hi_n_q;
                    lo_d    = lo_n_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
